qdiv: RTL and testbench

- Sequential signed fixed-point divider, Q-format two's complement; the inverse operation of the team's combinational fixed-point multiplier.
- Computes o_quotient = i_dividend / i_divisor in the same Q/N format.
- Radix-2 restoring algorithm, one quotient bit per clock, start/done handshake.
- Sits in the Mandelbrot datapath wherever a reciprocal or scaling division is needed (e.g. pixel-to-complex-plane step).

---
 rtl/fixed_point_pkg.sv | 15 +
 rtl/qdiv_if.sv | 23 ++
 rtl/q_abs.sv | 13 +
 rtl/qdiv.sv | 134 +++++++++++++
 tb/tb_qdiv.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/fixed_point_pkg.sv
// Shared fixed-point definitions for the Q-format arithmetic blocks (multiplier, divider).
package fixed_point_pkg;

    localparam int Q_DEF = 15;
    localparam int N_DEF = 32;

    localparam logic [N_DEF-1:0] ONE = N_DEF'(1) << Q_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/qdiv_if.sv
// Start/done handshake and operand/result bundle of the fixed-point divider.
interface qdiv_if #(
    parameter int N = 32
);
    logic         i_start;
    logic [N-1:0] i_dividend;
    logic [N-1:0] i_divisor;
    logic [N-1:0] o_quotient;
    logic         o_busy;
    logic         o_done;
    logic         o_ovr;
    logic         o_div0;

    modport master (
        output i_start, i_dividend, i_divisor,
        input  o_quotient, o_busy, o_done, o_ovr, o_div0
    );

    modport slave (
        input  i_start, i_dividend, i_divisor,
        output o_quotient, o_busy, o_done, o_ovr, o_div0
    );
endinterface

// File: rtl/q_abs.sv
// Two's-complement magnitude and sign extract; the most negative value maps to 2^(N-1).
module q_abs #(
    parameter int N = 32
) (
    input  logic [N-1:0] value,
    output logic [N-1:0] mag,
    output logic         neg
);

    assign neg = value[N-1];
    assign mag = neg ? (~value + N'(1)) : value;

endmodule

// File: rtl/qdiv.sv
// Sequential signed Q-format divider: radix-2 restoring, one quotient bit per clock.
module qdiv
    import fixed_point_pkg::*;
#(
    parameter int Q = Q_DEF,
    parameter int N = N_DEF
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    qdiv_if.slave  bus
);

    localparam int W  = N + Q;
    localparam int CW = $clog2(W + 1);

    state_t          state_r, state_s;
    logic [N:0]      rem_r, rem_shift_s, rem_next_s;
    logic [W-1:0]    quo_r, quo_next_s, dvd_r;
    logic [N-1:0]    div_r;
    logic [CW-1:0]   count_r;
    logic            sign_r;

    logic [N-1:0]    a_mag_s, b_mag_s, mag_s, result_s;
    logic            a_neg_s, b_neg_s, b_zero_s, accept_s, last_s, ovr_s;

    logic [N-1:0]    quotient_r;
    logic            busy_r, done_r, ovr_r, div0_r;

    q_abs #(.N(N)) u_abs_a (.value(bus.i_dividend), .mag(a_mag_s), .neg(a_neg_s));
    q_abs #(.N(N)) u_abs_b (.value(bus.i_divisor),  .mag(b_mag_s), .neg(b_neg_s));

    assign b_zero_s = (bus.i_divisor == {N{1'b0}});

    // Next-state decode and acceptance/last-iteration strobes.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.i_start) begin
                    accept_s = 1'b1;
                    state_s  = b_zero_s ? DONE : CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (count_r == CW'(1)) begin
                    last_s  = 1'b1;
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // One restoring step plus the signed, truncated result taken from the updated quotient.
    always_comb begin
        rem_shift_s = {rem_r[N-1:0], dvd_r[W-1]};
        if (rem_shift_s >= {1'b0, div_r}) begin
            rem_next_s = rem_shift_s - {1'b0, div_r};
            quo_next_s = {quo_r[W-2:0], 1'b1};
        end else begin
            rem_next_s = rem_shift_s;
            quo_next_s = {quo_r[W-2:0], 1'b0};
        end
        mag_s    = {1'b0, quo_next_s[N-2:0]};
        result_s = sign_r ? (~mag_s + N'(1)) : mag_s;
        ovr_s    = |quo_next_s[W-1:N-1];
    end

    // State register, datapath and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r    <= IDLE;
            rem_r      <= {(N+1){1'b0}};
            quo_r      <= {W{1'b0}};
            dvd_r      <= {W{1'b0}};
            div_r      <= {N{1'b0}};
            count_r    <= {CW{1'b0}};
            sign_r     <= 1'b0;
            quotient_r <= {N{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ovr_r      <= 1'b0;
            div0_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            done_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sign_r     <= a_neg_s ^ b_neg_s;
                        div_r      <= b_mag_s;
                        dvd_r      <= {a_mag_s, {Q{1'b0}}};
                        rem_r      <= {(N+1){1'b0}};
                        quo_r      <= {W{1'b0}};
                        count_r    <= CW'(W);
                        quotient_r <= {N{1'b0}};
                        ovr_r      <= b_zero_s;
                        div0_r     <= b_zero_s;
                        busy_r     <= ~b_zero_s;
                        done_r     <= b_zero_s;
                    end
                end
                CALC: begin
                    rem_r   <= rem_next_s;
                    quo_r   <= quo_next_s;
                    dvd_r   <= dvd_r << 1;
                    count_r <= count_r - CW'(1);
                    if (last_s) begin
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        quotient_r <= result_s;
                        ovr_r      <= ovr_s;
                    end
                end
                DONE:    ;
                default: ;
            endcase
        end
    end

    assign bus.o_quotient = quotient_r;
    assign bus.o_busy     = busy_r;
    assign bus.o_done     = done_r;
    assign bus.o_ovr      = ovr_r;
    assign bus.o_div0     = div0_r;

endmodule

// File: tb/tb_qdiv.sv
// Scoreboard bench for qdiv: expected results queued at start, popped and compared at o_done.
module tb_qdiv;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct {
        logic [31:0] q;
        logic        ovr;
        logic        div0;
        int          lat;
    } exp_t;

    exp_t sb[$];

    qdiv_if #(.N(32)) bus ();

    qdiv #(.Q(15), .N(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer long division of the scaled magnitudes, truncated toward zero.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        logic [31:0] ta, tb, mag;
        longint unsigned ma, mb, qq;
        if (b == 32'h0) begin
            r.q = 32'h0; r.ovr = 1'b1; r.div0 = 1'b1; r.lat = 1;
            return r;
        end
        ta = a[31] ? (32'h0 - a) : a;
        tb = b[31] ? (32'h0 - b) : b;
        ma = {32'h0, ta};
        mb = {32'h0, tb};
        qq = (ma << 15) / mb;
        r.ovr  = ((qq >> 31) != 64'h0);
        mag    = {1'b0, qq[30:0]};
        r.q    = (a[31] ^ b[31]) ? (32'h0 - mag) : mag;
        r.div0 = 1'b0;
        r.lat  = 48;
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_quot"}, 64'(bus.o_quotient), 64'h0);
        check({tag, "_busy"}, 64'(bus.o_busy), 64'h0);
        check({tag, "_done"}, 64'(bus.o_done), 64'h0);
        check({tag, "_ovr"},  64'(bus.o_ovr),  64'h0);
        check({tag, "_div0"}, 64'(bus.o_div0), 64'h0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int poke_at, input int rst_at, input string tag);
        exp_t e;
        int   cyc;
        int   extra;
        int   window;
        bit   got;
        sb.push_back(model(a, b));
        @(negedge clk);
        bus.i_dividend = a;
        bus.i_divisor  = b;
        bus.i_start    = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start    = 1'b0;
        bus.i_dividend = $urandom;
        bus.i_divisor  = $urandom;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            bus.i_start = 1'b0;
            if (bus.o_done) begin
                got = 1'b1;
            end else if (cyc == rst_at) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                check_all_zero({tag, "_abort"});
                rst_n = 1'b1;
                e = sb.pop_front();
                extra = 0;
                repeat (60) begin
                    @(negedge clk);
                    if (bus.o_done) extra++;
                end
                check({tag, "_no_done_after_abort"}, 64'(extra), 64'h0);
                return;
            end else begin
                if (cyc == 1) check({tag, "_busy_early"}, 64'(bus.o_busy), 64'h1);
                if (cyc == poke_at) begin
                    bus.i_start    = 1'b1;
                    bus.i_dividend = 32'h0003_0000;
                    bus.i_divisor  = 32'h0000_4000;
                end
            end
        end
        e = sb.pop_front();
        if (!got) begin
            check({tag, "_timeout"}, 64'h0, 64'h1);
            return;
        end
        check({tag, "_latency"}, 64'(cyc), 64'(e.lat));
        check({tag, "_quot"},    64'(bus.o_quotient), 64'(e.q));
        check({tag, "_ovr"},     64'(bus.o_ovr),  64'(e.ovr));
        check({tag, "_div0"},    64'(bus.o_div0), 64'(e.div0));
        check({tag, "_busy_done"}, 64'(bus.o_busy), 64'h0);
        window = (poke_at > 0) ? 60 : 3;
        extra  = 0;
        repeat (window) begin
            @(negedge clk);
            if (bus.o_done) extra++;
        end
        check({tag, "_single_done"}, 64'(extra), 64'h0);
        check({tag, "_held"}, 64'(bus.o_quotient), 64'(e.q));
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.i_start    = 1'b0;
        bus.i_dividend = 32'h0;
        bus.i_divisor  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h0001_8000, 32'h0001_0000, 0, 0, "p3_div_2");
        run_op(32'hFFFE_8000, 32'h0001_0000, 0, 0, "m3_div_2");
        run_op(32'h0000_8000, 32'hFFFE_8000, 0, 0, "p1_div_m3");
        run_op(32'h4000_0000, 32'h0000_4000, 0, 0, "ovr_big");
        run_op(32'h0000_8000, 32'h0000_8000, 0, 0, "one_div_one");
        run_op(32'h0001_0000, 32'h0000_0000, 0, 0, "div0");
        run_op(32'h0000_0000, 32'h0000_5000, 0, 0, "zero_dividend");
        run_op(32'h8000_0000, 32'h0000_8000, 0, 0, "most_neg");
        run_op(32'h0001_8000, 32'h0001_0000, 10, 0, "ignore_start");
        run_op(32'h0001_8000, 32'h0001_0000, 0, 20, "reset_mid");
        run_op(32'h0001_8000, 32'h0001_0000, 0, 0, "after_reset");
        for (int i = 0; i < 4; i++) begin
            run_op($urandom, $urandom_range(32'h0010_0000, 32'h0000_0100), 0, 0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
